lut_cfg_loader: RTL

Configuration writer for the fabric's LUT array. LUTs only consume their truth-table select bits; this block loads those bits.
- Accepts configuration words over a valid/ready stream and assembles them in a shadow register.
- Verifies an XOR checksum word, then commits all LUT config bits to the fabric atomically.
- Sits between the key/bitstream source and the LUT array; a failed load never disturbs the live configuration.

---
 rtl/lut_cfg_pkg.sv | 22 ++
 rtl/lut_cfg_checksum.sv | 38 +++
 rtl/lut_cfg_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types and defaults for the LUT configuration loader.
package lut_cfg_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    localparam int DEF_NUM_LUTS = 16;
    localparam int DEF_CFG_BITS = 4;
    localparam int DEF_WORD_W   = 8;

    // Number of stream words needed to carry 'total' config bits
    function automatic int calc_nwords(input int total, input int word_w);
        return (total + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/lut_cfg_checksum.sv
// Running XOR accumulator over accepted configuration words.
// clr has priority over en; acc is the XOR of all words since the last clr.
module lut_cfg_checksum #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] acc
);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;

    // Next accumulator value: clear, fold in a word, or hold
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/lut_cfg_loader.sv
// LUT configuration loader: assembles stream words into a shadow register,
// verifies a trailing XOR checksum word and commits the whole configuration
// to cfg_out in a single edge. A failed load leaves cfg_out untouched.
// Optional macro LUT_CFG_READBACK_EN adds a combinational word readback port
// (rd_addr / rd_data) onto the committed configuration.
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter  int NUM_LUTS = DEF_NUM_LUTS,
    parameter  int CFG_BITS = DEF_CFG_BITS,
    parameter  int WORD_W   = DEF_WORD_W,
    localparam int TOTAL    = NUM_LUTS * CFG_BITS,
    localparam int NWORDS   = calc_nwords(TOTAL, WORD_W),
    localparam int AW       = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic [TOTAL-1:0]  cfg_out,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef LUT_CFG_READBACK_EN
    ,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
`endif
);

    // Shadow spans whole words; bits above TOTAL are simply never committed
    localparam int SH_W = NWORDS * WORD_W;

    state_e            state_q, state_d;
    logic [SH_W-1:0]   shadow_q, shadow_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [TOTAL-1:0]  cfg_q, cfg_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic              cks_clr;
    logic              cks_en;
    logic [WORD_W-1:0] cks_acc;

    lut_cfg_checksum #(
        .WORD_W (WORD_W)
    ) u_checksum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cks_clr),
        .en    (cks_en),
        .din   (in_data),
        .acc   (cks_acc)
    );

    // in_ready is a flop, so acceptance never depends combinationally on in_valid
    assign xfer = in_valid && in_ready_q;

    // Next-state and datapath update; start overrides any word on the same edge
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        done_d   = done_q;
        err_d    = err_q;
        cks_clr  = 1'b0;
        cks_en   = 1'b0;

        if (start) begin
            state_d  = LOAD;
            shadow_d = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            cks_clr  = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer) begin
                        for (int k = 0; k < NWORDS; k++) begin
                            if (cnt_q == AW'(k)) begin
                                shadow_d[k*WORD_W +: WORD_W] = in_data;
                            end
                        end
                        cnt_d  = cnt_q + 1'b1;
                        cks_en = 1'b1;
                        if (cnt_q == AW'(NWORDS - 1)) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (in_data == cks_acc) begin
                            cfg_d   = shadow_q[TOTAL-1:0];
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        in_ready_d = (state_d == LOAD) || (state_d == CHECK);
        busy_d     = (state_d == LOAD) || (state_d == CHECK);
    end

    // All loader state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign cfg_out  = cfg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

`ifdef LUT_CFG_READBACK_EN
    logic [SH_W-1:0] cfg_pad;

    assign cfg_pad = SH_W'(cfg_q);

    // Word-indexed view of the committed config; unmatched addresses read 0
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (rd_addr == AW'(k)) begin
                rd_data = cfg_pad[k*WORD_W +: WORD_W];
            end
        end
    end
`endif

endmodule
